// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants: operand indices, forwarding selects, controller states.
package pipeline_pkg;

  localparam int unsigned IDX_RS1 = 0;
  localparam int unsigned IDX_RS2 = 1;

  localparam int unsigned FWD_W = 2;

  localparam logic [FWD_W-1:0] NO_FWD     = 2'd0;
  localparam logic [FWD_W-1:0] MEM_TO_ALU = 2'd1;
  localparam logic [FWD_W-1:0] WB_TO_ALU  = 2'd2;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// EX operand forwarding: compares EX sources against MEM and WB destinations, MEM wins.
module fwd_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned RF_SIZE = 5
) (
  input  logic [RF_SIZE-1:0] ex_rs1,
  input  logic [RF_SIZE-1:0] ex_rs2,
  input  logic [1:0]         ex_rs_en,
  input  logic [RF_SIZE-1:0] mem_rd,
  input  logic               mem_reg_wen,
  input  logic [RF_SIZE-1:0] wb_rd,
  input  logic               wb_reg_wen,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b
);

  logic mem_hit_a;
  logic mem_hit_b;
  logic wb_hit_a;
  logic wb_hit_b;

  // Producer match per source; x0 is never forwarded since it always reads zero.
  always_comb begin
    mem_hit_a = ex_rs_en[IDX_RS1] & mem_reg_wen & (mem_rd != '0) & (mem_rd == ex_rs1);
    mem_hit_b = ex_rs_en[IDX_RS2] & mem_reg_wen & (mem_rd != '0) & (mem_rd == ex_rs2);
    wb_hit_a  = ex_rs_en[IDX_RS1] & wb_reg_wen  & (wb_rd  != '0) & (wb_rd  == ex_rs1);
    wb_hit_b  = ex_rs_en[IDX_RS2] & wb_reg_wen  & (wb_rd  != '0) & (wb_rd  == ex_rs2);
  end

  // Select encoding; MEM holds the younger result so it takes priority over WB.
  always_comb begin
    fwd_a = NO_FWD;
    fwd_b = NO_FWD;
    if (mem_hit_a)     fwd_a = MEM_TO_ALU;
    else if (wb_hit_a) fwd_a = WB_TO_ALU;
    if (mem_hit_b)     fwd_b = MEM_TO_ALU;
    else if (wb_hit_b) fwd_b = WB_TO_ALU;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: stage enables/flushes,
// forwarding selects, memory-wait watchdog and saturating debug counters.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned RF_SIZE = 5,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RF_SIZE-1:0] id_rs1,
  input  logic [RF_SIZE-1:0] id_rs2,
  input  logic [1:0]         id_rs_en,
  input  logic [RF_SIZE-1:0] ex_rs1,
  input  logic [RF_SIZE-1:0] ex_rs2,
  input  logic [1:0]         ex_rs_en,
  input  logic [RF_SIZE-1:0] ex_rd,
  input  logic               ex_reg_wen,
  input  logic               ex_mem_ren,
  input  logic               ex_redirect,
  input  logic [RF_SIZE-1:0] mem_rd,
  input  logic               mem_reg_wen,
  input  logic [RF_SIZE-1:0] wb_rd,
  input  logic               wb_reg_wen,
  input  logic               dmem_req,
  input  logic               dmem_ack,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               idex_en,
  output logic               exmem_en,
  output logic               memwb_en,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               mem_timeout,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   flush_count
);

  localparam int unsigned WAIT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  ctrl_state_t       state;
  ctrl_state_t       state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_nxt;
  logic              freeze;
  logic              load_use;
  logic              redirect_take;
  logic [1:0]        fwd_a_raw;
  logic [1:0]        fwd_b_raw;

  // Hazard detection terms.
  always_comb begin
    freeze   = dmem_req & ~dmem_ack;
    load_use = ex_mem_ren & ex_reg_wen & (ex_rd != '0) &
               ((id_rs_en[IDX_RS1] & (id_rs1 == ex_rd)) |
                (id_rs_en[IDX_RS2] & (id_rs2 == ex_rd)));
  end

  // Next state and stage controls; priority reset > freeze > redirect > load-use > run.
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = '0;
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    idex_en       = 1'b1;
    exmem_en      = 1'b1;
    memwb_en      = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    redirect_take = 1'b0;

    if (rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (freeze) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (ex_redirect) begin
      // The ID instruction is wrong-path, so a coincident load-use is irrelevant.
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      redirect_take = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end

    case (state)
      RUN: begin
        if (freeze) state_nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (dmem_ack || !dmem_req) state_nxt = RUN;
        wait_cnt_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);
      end
      default: state_nxt = RUN;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Memory-wait watchdog; the flag latches in the edge the count reaches TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
      if (state == MEM_WAIT && wait_cnt_nxt == WAIT_MAX) mem_timeout <= 1'b1;
    end
  end

  // Saturating stall and flush counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_en && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
      if (redirect_take && flush_count != '1) flush_count <= flush_count + CNT_W'(1);
    end
  end

  fwd_unit #(
    .RF_SIZE (RF_SIZE)
  ) u_fwd_unit (
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .ex_rs_en    (ex_rs_en),
    .mem_rd      (mem_rd),
    .mem_reg_wen (mem_reg_wen),
    .wb_rd       (wb_rd),
    .wb_reg_wen  (wb_reg_wen),
    .fwd_a       (fwd_a_raw),
    .fwd_b       (fwd_b_raw)
  );

  // Forwarding selects read NO_FWD while reset is held.
  always_comb begin
    fwd_a = rst ? NO_FWD : fwd_a_raw;
    fwd_b = rst ? NO_FWD : fwd_b_raw;
  end

endmodule
